mskaes_32bits_round_controller: RTL
===================================

// Module: MSKaes_32bits_round_controller
// PURPOSE
//  Sequences the masked 32-bit AES state datapath (4 bytes/cycle) for encryption or decryption.
//  Accepts a start handshake, gates each column step on fresh S-box randomness and drives the
//  datapath routing controls. Requests round-key columns, pauses for the S-box pipeline after
//  each round, and presents a done handshake.
//  Sits between the top-level control and the state datapath, the key scheduler and the PRNG.
// PARAMETERS
//  NROUNDS  10  number of full rounds (AES-128); round_idx counts 0..NROUNDS-1
//  SB_LAT   4   masked S-box pipeline latency in cycles; WAIT state length between rounds
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous reset, active-high
//  in_valid       in   1  start request; plaintext/ciphertext shares stable on datapath input
//  in_inverse     in   1  mode sampled at start: 0 = encrypt, 1 = decrypt
//  in_ready       out  1  controller idle, start accepted when in_valid & in_ready
//  rnd_valid      in   1  fresh S-box randomness available this cycle
//  rnd_ready      out  1  randomness consumed this cycle
//  key_col_req    out  1  key scheduler must present the next round-key column this cycle
//  dp_enable      out  1  state register shift enable
//  sb_enable      out  1  S-box pipeline enable
//  dp_init        out  1  load plaintext shares into the state register
//  dp_en_MC       out  1  route through (Inv)MixColumns
//  dp_en_loop     out  1  loop-back routing (final AddRoundKey)
//  dp_en_inverse  out  1  decryption routing; equals the latched mode
//  dp_in_AKfinal  out  1  final AddRoundKey phase
//  round_idx      out  4  current round index
//  col_idx        out  2  current column index
//  out_valid      out  1  result shares valid on datapath output
//  out_ready      in   1  consumer accepts the result
// BEHAVIOUR
//  States: IDLE, ROUND, WAIT, FINAL, DONE. All outputs are decoded from registered state, counters and mode.
//  Reset: state=IDLE, round_idx=0, col_idx=0, mode=0.
//   All outputs are 0 except in_ready=1, in the cycle after rst is seen.
//  IDLE: in_ready=1.
//   On in_valid: dp_init=1, dp_enable=1 in that same cycle; in_inverse is latched; go to ROUND with round 0, column 0.
//  ROUND: a step happens only in cycles with rnd_valid=1. In a step cycle these are asserted:
//   dp_enable, sb_enable, rnd_ready, key_col_req; col_idx then increments.
//   In a cycle with rnd_valid=0: dp_enable, sb_enable, rnd_ready and key_col_req are all 0.
//   Counters hold, and stalls of any length are legal.
//   When the step at col_idx=3 completes: col_idx wraps to 0 and the state goes to WAIT.
//  WAIT: runs for exactly SB_LAT cycles with sb_enable=1, dp_enable=0, rnd_ready=0.
//   If round_idx<NROUNDS-1: round_idx increments and the state returns to ROUND.
//   Otherwise the state goes to FINAL.
//  dp_en_MC (ROUND/WAIT): encrypt: 1 for round_idx 0..NROUNDS-2. Decrypt: 1 for round_idx 1..NROUNDS-1.
//   0 otherwise.
//  FINAL: runs 4 cycles with dp_enable, key_col_req, dp_en_loop and dp_in_AKfinal all =1.
//   No randomness is used (rnd_ready=0) and there are no stalls. col_idx counts 0..3; then the state goes to DONE.
//  DONE: out_valid=1 and is held until out_ready. In the cycle where out_valid & out_ready:
//   the state goes to IDLE and round_idx and col_idx clear.
//   in_ready=0 in every state except IDLE, so back-to-back accept in that same cycle is not allowed.
//  dp_en_inverse = latched mode in every state except IDLE.
//  Latency with no stalls: accept at cycle t0 gives out_valid at t0+1+NROUNDS*(4+SB_LAT)+4.
//   With defaults that is t0+85.
//  rst has priority in every state: mid-operation it aborts to IDLE in the next cycle.
//   No out_valid is produced for the aborted operation.
//  in_valid in any state except IDLE is ignored. in_inverse is ignored except at accept.
// TESTING
//  Reset then idle: in_ready=1, all dp_* = 0, out_valid=0. Hold in_valid=0 for 10 cycles -> nothing changes.
//  Encrypt, rnd_valid=1 always, FIPS-197 key/pt, 2 shares:
//   out_valid at t0+85; recombined output 3925841d02dc09fbdc118597196a0b32.
//  Decrypt of the same ciphertext -> recovered plaintext 3243f6a8885a308d313198a2e0370734.
//   dp_en_MC=0 in round 0 and =1 in round 9.
//  Random rnd_valid (50%) -> result unchanged; rnd_ready count = 40; out_valid delayed by exactly the number of stall cycles.
//  rst asserted at round 5, column 2 -> IDLE next cycle, in_ready=1, no out_valid.
//   A new encrypt after that is correct.
//  out_ready held low 20 cycles after out_valid -> out_valid stays 1, in_ready stays 0.
//   out_ready=1 -> IDLE in the next cycle.

Source files
------------

// File: rtl/mskaes_32bits_round_controller_if.sv
// Control bundle between the masked AES round controller and its neighbours
// (top-level control, state datapath, key scheduler, PRNG).
interface mskaes_32bits_round_controller_if;
  logic       in_valid;
  logic       in_inverse;
  logic       in_ready;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       key_col_req;
  logic       dp_enable;
  logic       sb_enable;
  logic       dp_init;
  logic       dp_en_MC;
  logic       dp_en_loop;
  logic       dp_en_inverse;
  logic       dp_in_AKfinal;
  logic [3:0] round_idx;
  logic [1:0] col_idx;
  logic       out_valid;
  logic       out_ready;

  // Controller side
  modport master (
    input  in_valid, in_inverse, rnd_valid, out_ready,
    output in_ready, rnd_ready, key_col_req, dp_enable, sb_enable, dp_init,
           dp_en_MC, dp_en_loop, dp_en_inverse, dp_in_AKfinal, round_idx, col_idx,
           out_valid
  );

  // Environment side
  modport slave (
    output in_valid, in_inverse, rnd_valid, out_ready,
    input  in_ready, rnd_ready, key_col_req, dp_enable, sb_enable, dp_init,
           dp_en_MC, dp_en_loop, dp_en_inverse, dp_in_AKfinal, round_idx, col_idx,
           out_valid
  );
endinterface

// File: rtl/mskaes_32bits_round_controller.sv
// Round sequencer for the masked 32-bit AES datapath: one column per cycle, gated on
// fresh S-box randomness, with an S-box drain wait between rounds and a final AddRoundKey pass.
module mskaes_32bits_round_controller #(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned SB_LAT  = 4
) (
  input logic                                 clk,
  input logic                                 rst,
  mskaes_32bits_round_controller_if.master    ctrl
);

  localparam int unsigned WaitW = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
  localparam logic [WaitW-1:0] WaitLast  = WaitW'(SB_LAT - 1);
  localparam logic [3:0]       LastRound = 4'(NROUNDS - 1);

  typedef enum logic [2:0] {StIdle, StRound, StWait, StFinal, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       col_q, col_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mode_q, mode_d;
  logic             mc_round;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      col_q   <= '0;
      wait_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
    end
  end

  // Encryption skips MixColumns in the last round, decryption skips it in the first.
  assign mc_round = mode_q ? (round_q != 4'd0) : (round_q != LastRound);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    col_d   = col_q;
    wait_d  = wait_q;
    mode_d  = mode_q;

    ctrl.in_ready      = 1'b0;
    ctrl.rnd_ready     = 1'b0;
    ctrl.key_col_req   = 1'b0;
    ctrl.dp_enable     = 1'b0;
    ctrl.sb_enable     = 1'b0;
    ctrl.dp_init       = 1'b0;
    ctrl.dp_en_MC      = 1'b0;
    ctrl.dp_en_loop    = 1'b0;
    ctrl.dp_in_AKfinal = 1'b0;
    ctrl.out_valid     = 1'b0;
    ctrl.dp_en_inverse = (state_q != StIdle) & mode_q;
    ctrl.round_idx     = round_q;
    ctrl.col_idx       = col_q;

    unique case (state_q)
      StIdle: begin
        ctrl.in_ready = 1'b1;
        if (ctrl.in_valid) begin
          ctrl.dp_init   = 1'b1;
          ctrl.dp_enable = 1'b1;
          mode_d         = ctrl.in_inverse;
          round_d        = '0;
          col_d          = '0;
          state_d        = StRound;
        end
      end
      StRound: begin
        ctrl.dp_en_MC = mc_round;
        if (ctrl.rnd_valid) begin
          ctrl.dp_enable   = 1'b1;
          ctrl.sb_enable   = 1'b1;
          ctrl.rnd_ready   = 1'b1;
          ctrl.key_col_req = 1'b1;
          col_d            = col_q + 2'd1;
          if (col_q == 2'd3) begin
            wait_d  = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        ctrl.sb_enable = 1'b1;
        ctrl.dp_en_MC  = mc_round;
        if (wait_q == WaitLast) begin
          if (round_q < LastRound) begin
            round_d = round_q + 4'd1;
            state_d = StRound;
          end else begin
            state_d = StFinal;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StFinal: begin
        ctrl.dp_enable     = 1'b1;
        ctrl.key_col_req   = 1'b1;
        ctrl.dp_en_loop    = 1'b1;
        ctrl.dp_in_AKfinal = 1'b1;
        col_d              = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ctrl.out_valid = 1'b1;
        if (ctrl.out_ready) begin
          round_d = '0;
          col_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
